// File: rtl/tpu_pkg.sv
// tpu_pkg: shared widths, matrix geometry and element address map for the feeder.
package tpu_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int MAT_DIM    = 2;
  localparam int NUM_ELEMS  = 8;
  localparam int W00 = 0;
  localparam int W01 = 1;
  localparam int W10 = 2;
  localparam int W11 = 3;
  localparam int A00 = 4;
  localparam int A01 = 5;
  localparam int A10 = 6;
  localparam int A11 = 7;
  localparam logic [2:0] SLOT_CLR = 3'd5;
endpackage

// File: rtl/mat_buf.sv
// mat_buf: 8-entry element register file with a written-mask that tracks load completeness.
module mat_buf
  import tpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [2:0]                    waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          clr_mask,
  output logic [NUM_ELEMS*DATA_W-1:0]   mem,
  output logic [NUM_ELEMS-1:0]          mask
);
  logic [NUM_ELEMS*DATA_W-1:0] mem_d, mem_q;
  logic [NUM_ELEMS-1:0]        mask_d, mask_q;
  always_comb begin
    mem_d  = mem_q;
    mask_d = clr_mask ? '0 : mask_q;
    if (we) begin
      mem_d[int'(waddr)*DATA_W +: DATA_W] = wdata;
      mask_d[waddr] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q  <= '0;
      mask_q <= '0;
    end else begin
      mem_q  <= mem_d;
      mask_q <= mask_d;
    end
  end
  assign mem  = mem_q;
  assign mask = mask_q;
endmodule

// File: rtl/mat_feeder.sv
// mat_feeder: loads a 2x2 weight and input matrix, then feeds them skewed to a 2x2 MMU.
// Optional MAT_FEEDER_LOAD_CHECK_EN builds the sticky load_err protocol checker.
module mat_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] host_data,
  input  logic              wm_load_mat,
  input  logic [2:0]        wm_addr,
  input  logic              feeding_en,
  input  logic [2:0]        mmu_cycles,
  output logic [DATA_W-1:0] a_row0,
  output logic [DATA_W-1:0] a_row1,
  output logic [DATA_W-1:0] b_col0,
  output logic [DATA_W-1:0] b_col1,
  output logic              feed_valid,
  output logic              load_done,
  output logic              load_err
);
  logic [NUM_ELEMS*DATA_W-1:0] mem;
  logic [NUM_ELEMS-1:0]        mask;
  logic [DATA_W-1:0]           e [NUM_ELEMS];
  logic s0, s1, s2;
  logic [DATA_W-1:0] a_row0_d, a_row0_q, a_row1_d, a_row1_q;
  logic [DATA_W-1:0] b_col0_d, b_col0_q, b_col1_d, b_col1_q;
  logic feed_valid_d, feed_valid_q;
  mat_buf #(.DATA_W(DATA_W)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wm_load_mat && !feeding_en),
    .waddr    (wm_addr),
    .wdata    (host_data),
    .clr_mask (feeding_en && mmu_cycles == SLOT_CLR),
    .mem      (mem),
    .mask     (mask)
  );
  always_comb begin
    for (int i = 0; i < NUM_ELEMS; i++) e[i] = mem[i*DATA_W +: DATA_W];
    s0 = feeding_en && mmu_cycles == 3'd0;
    s1 = feeding_en && mmu_cycles == 3'd1;
    s2 = feeding_en && mmu_cycles == 3'd2;
    a_row0_d     = s0 ? e[A00] : s1 ? e[A01] : '0;
    a_row1_d     = s1 ? e[A10] : s2 ? e[A11] : '0;
    b_col0_d     = s0 ? e[W00] : s1 ? e[W10] : '0;
    b_col1_d     = s1 ? e[W01] : s2 ? e[W11] : '0;
    feed_valid_d = s0 || s1 || s2;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_row0_q     <= '0;
      a_row1_q     <= '0;
      b_col0_q     <= '0;
      b_col1_q     <= '0;
      feed_valid_q <= 1'b0;
    end else begin
      a_row0_q     <= a_row0_d;
      a_row1_q     <= a_row1_d;
      b_col0_q     <= b_col0_d;
      b_col1_q     <= b_col1_d;
      feed_valid_q <= feed_valid_d;
    end
  end
  assign a_row0     = a_row0_q;
  assign a_row1     = a_row1_q;
  assign b_col0     = b_col0_q;
  assign b_col1     = b_col1_q;
  assign feed_valid = feed_valid_q;
  assign load_done  = &mask;
`ifdef MAT_FEEDER_LOAD_CHECK_EN
  logic load_err_d, load_err_q;
  // Error on starting a feed before the load completes, or on a write dropped during feeding.
  always_comb
    load_err_d = load_err_q || (s0 && !(&mask)) || (wm_load_mat && feeding_en);
  always_ff @(posedge clk) begin
    if (!rst_n) load_err_q <= 1'b0;
    else        load_err_q <= load_err_d;
  end
  assign load_err = load_err_q;
`else
  assign load_err = 1'b0;
`endif
endmodule
